cla_adder_pipe: RTL



---
 rtl/cla_pkg.sv | 12 +
 rtl/cla_adder_pipe_cla8.sv | 50 +++++
 rtl/cla_adder_pipe.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder.
// Group width and operation encodings.
package cla_pkg;

    localparam int GRP_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

endpackage

// File: rtl/cla_adder_pipe_cla8.sv
// Combinational 8-bit carry-lookahead group.
// Every carry is a flat sum of products of g/p/ci.
module cla8
    import cla_pkg::*;
(
    input  logic [GRP_W-1:0] a,
    input  logic [GRP_W-1:0] b,
    input  logic             ci,
    output logic [GRP_W-1:0] s,
    output logic             co,
    output logic             c7
);

    logic [GRP_W-1:0] g;
    logic [GRP_W-1:0] p;
    logic [GRP_W:0]   c;
    logic             t;
    logic             cc;

    assign g = a & b;
    assign p = a | b;

    // carry i+1 built from g/p/ci only, never from carry i
    always_comb begin
        c  = '0;
        t  = 1'b0;
        cc = 1'b0;
        c[0] = ci;
        for (int i = 0; i < GRP_W; i++) begin
            t = ci;
            for (int j = 0; j <= i; j++) begin
                t = t & p[j];
            end
            cc = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    t = t & p[m];
                end
                cc = cc | t;
            end
            c[i+1] = cc;
        end
    end

    assign s  = a ^ b ^ c[GRP_W-1:0];
    assign co = c[GRP_W];
    assign c7 = c[GRP_W-1];

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined adder/subtractor, one 8-bit lookahead group per stage.
// Whole pipeline stalls together on output backpressure.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NGRP = WIDTH / GRP_W;

    if (WIDTH % GRP_W != 0 || WIDTH < GRP_W) begin : chk
        $error("WIDTH must be a positive multiple of 8");
    end

    logic             adv;
    logic [WIDTH-1:0] ea;
    logic [WIDTH-1:0] eb;
    logic             ecin;

    assign adv       = !out_valid | out_ready;
    assign in_ready  = adv;
    assign ea        = a;

    // map op onto an add of a, optionally inverted b, and carry-in
    always_comb begin
        eb   = b;
        ecin = 1'b0;
        unique case (op)
            OP_ADD: begin eb = b;  ecin = 1'b0; end
            OP_ADC: begin eb = b;  ecin = cin;  end
            OP_SUB: begin eb = ~b; ecin = 1'b1; end
            OP_SBC: begin eb = ~b; ecin = cin;  end
        endcase
    end

    for (genvar k = 0; k < NGRP; k++) begin : stg
        logic [GRP_W-1:0]         ga;
        logic [GRP_W-1:0]         gb;
        logic [GRP_W-1:0]         gs;
        logic                     gci;
        logic                     gco;
        logic                     gc7;
        logic                     v_d;
        logic [GRP_W*(k+1)-1:0]   s_d;
        logic                     v_q;
        logic                     c_q;
        logic [GRP_W*(k+1)-1:0]   s_q;

        if (k == 0) begin : src
            assign ga  = ea[GRP_W-1:0];
            assign gb  = eb[GRP_W-1:0];
            assign gci = ecin;
            assign v_d = in_valid;
            assign s_d = gs;
        end else begin : src
            assign ga  = stg[k-1].mid.ua_q[GRP_W-1:0];
            assign gb  = stg[k-1].mid.ub_q[GRP_W-1:0];
            assign gci = stg[k-1].c_q;
            assign v_d = stg[k-1].v_q;
            assign s_d = {gs, stg[k-1].s_q};
        end

        cla8 u_grp (
            .a  (ga),
            .b  (gb),
            .ci (gci),
            .s  (gs),
            .co (gco),
            .c7 (gc7)
        );

        // beat valid, partial sum and group carry advance together
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (adv) begin
                v_q <= v_d;
                c_q <= gco;
                s_q <= s_d;
            end
        end

        if (k < NGRP - 1) begin : mid
            localparam int UW = WIDTH - GRP_W * (k + 1);
            logic [UW-1:0] ua_d;
            logic [UW-1:0] ub_d;
            logic [UW-1:0] ua_q;
            logic [UW-1:0] ub_q;
            logic          unused_c7;

            assign unused_c7 = gc7;

            if (k == 0) begin : nxt
                assign ua_d = ea[WIDTH-1:GRP_W];
                assign ub_d = eb[WIDTH-1:GRP_W];
            end else begin : nxt
                assign ua_d = stg[k-1].mid.ua_q[UW+GRP_W-1:GRP_W];
                assign ub_d = stg[k-1].mid.ub_q[UW+GRP_W-1:GRP_W];
            end

            // operand bits not yet consumed ride along with the beat
            always_ff @(posedge clk) begin
                if (rst) begin
                    ua_q <= '0;
                    ub_q <= '0;
                end else if (adv) begin
                    ua_q <= ua_d;
                    ub_q <= ub_d;
                end
            end
        end else begin : fin
            logic ovf_q;
            logic zero_q;

            // flags need the top group's carries and the full sum
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv) begin
                    ovf_q  <= gc7 ^ gco;
                    zero_q <= (s_d == '0);
                end
            end
        end
    end

    assign out_valid = stg[NGRP-1].v_q;
    assign sum       = stg[NGRP-1].s_q;
    assign cout      = stg[NGRP-1].c_q;
    assign ovf       = stg[NGRP-1].fin.ovf_q;
    assign zero      = stg[NGRP-1].fin.zero_q;

endmodule
